// File: rtl/regfile_sb.sv
// regfile_sb: register file with byte-lane writes, write-to-read bypass,
// optional hard-zero R0, a pending-write scoreboard and a sequential clear engine.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear_req / ready   start a runtime clear / clear done, ports accepted
//   ra_* / rb_*         two combinational read ports (addr, data, pend)
//   wr_*                single write port with byte-lane enables wr_be
//   rsv_en / rsv_addr   reserve a destination (set its pending bit)
//   rsv_err             one-cycle pulse: reserve hit an already-pending register
//   dbg_regs            flat dump of all registers, reg k at [k*DATA_W +: DATA_W]
module regfile_sb #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear_req,
   output logic                            ready,
   input  logic [ADDR_W-1:0]               ra_addr,
   output logic [DATA_W-1:0]               ra_data,
   output logic                            ra_pend,
   input  logic [ADDR_W-1:0]               rb_addr,
   output logic [DATA_W-1:0]               rb_data,
   output logic                            rb_pend,
   input  logic                            wr_en,
   input  logic [ADDR_W-1:0]               wr_addr,
   input  logic [DATA_W-1:0]               wr_data,
   input  logic [DATA_W/8-1:0]             wr_be,
   input  logic                            rsv_en,
   input  logic [ADDR_W-1:0]               rsv_addr,
   output logic                            rsv_err,
   output logic [(2**ADDR_W)*DATA_W-1:0]   dbg_regs
);
   localparam int BYTES = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {CLEAR, READY} state_t;
   state_t            state, state_nx;
   logic [ADDR_W-1:0] ctr, ctr_nx;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DATA_W-1:0] merged;
   logic              wr_ok, rsv_ok, ra_hide, rb_hide;
   assign ready  = (state == READY);
   // Port operations only count in READY; R0 swallows them when hard-wired to zero.
   assign wr_ok  = ready & wr_en  & ~(ZERO_R0 && wr_addr  == '0);
   assign rsv_ok = ready & rsv_en & ~(ZERO_R0 && rsv_addr == '0);
   always_comb begin
      state_nx = state;
      ctr_nx   = ctr;
      if (state == CLEAR) begin
         ctr_nx   = ctr + 1'b1;
         state_nx = (ctr == ADDR_W'(DEPTH - 1)) ? READY : CLEAR;
      end else if (clear_req) begin
         state_nx = CLEAR;
         ctr_nx   = '0;
      end
   end
   always_comb begin
      merged = regs[wr_addr];
      for (int i = 0; i < BYTES; i++)
         merged[8*i +: 8] = wr_be[i] ? wr_data[8*i +: 8] : regs[wr_addr][8*i +: 8];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         ctr     <= '0;
         pend    <= '0;
         rsv_err <= 1'b0;
      end else begin
         state   <= state_nx;
         ctr     <= ctr_nx;
         rsv_err <= rsv_ok & pend[rsv_addr];
         if (ready && clear_req)
            pend <= '0;
         else begin
            // Reserve is applied after the write so a same-cycle set wins.
            if (wr_ok)
               pend[wr_addr] <= 1'b0;
            if (rsv_ok)
               pend[rsv_addr] <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            regs[ctr] <= '0;
         else if (wr_ok)
            regs[wr_addr] <= merged;
      end
   end
   assign ra_hide = ~ready | (ZERO_R0 && ra_addr == '0);
   assign rb_hide = ~ready | (ZERO_R0 && rb_addr == '0);
   assign ra_data = ra_hide ? '0 : (BYPASS && wr_ok && wr_addr == ra_addr) ? merged : regs[ra_addr];
   assign rb_data = rb_hide ? '0 : (BYPASS && wr_ok && wr_addr == rb_addr) ? merged : regs[rb_addr];
   assign ra_pend = ~ra_hide & pend[ra_addr];
   assign rb_pend = ~rb_hide & pend[rb_addr];
   for (genvar k = 0; k < DEPTH; k++) begin : g_dbg
      assign dbg_regs[k*DATA_W +: DATA_W] = (ZERO_R0 && k == 0) ? '0 : regs[k];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb.
// Three instances share all inputs: u0 default (BYPASS=1, ZERO_R0=0),
// u1 with BYPASS=0, u2 with ZERO_R0=1.
module tb_regfile_sb;
   logic          clk = 1'b0;
   logic          rst, clear_req, wr_en, rsv_en;
   logic [2:0]    ra_addr, rb_addr, wr_addr, rsv_addr;
   logic [15:0]   wr_data;
   logic [1:0]    wr_be;
   logic          rdy [3];
   logic [15:0]   rad [3];
   logic [15:0]   rbd [3];
   logic          rap [3];
   logic          rbp [3];
   logic          err [3];
   logic [127:0]  dbg [3];
   int            checks = 0;
   int            failures = 0;
   always #5 clk = ~clk;
   regfile_sb #(.BYPASS(1'b1), .ZERO_R0(1'b0)) u0 (
      .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy[0]),
      .ra_addr(ra_addr), .ra_data(rad[0]), .ra_pend(rap[0]),
      .rb_addr(rb_addr), .rb_data(rbd[0]), .rb_pend(rbp[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(err[0]), .dbg_regs(dbg[0]));
   regfile_sb #(.BYPASS(1'b0), .ZERO_R0(1'b0)) u1 (
      .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy[1]),
      .ra_addr(ra_addr), .ra_data(rad[1]), .ra_pend(rap[1]),
      .rb_addr(rb_addr), .rb_data(rbd[1]), .rb_pend(rbp[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(err[1]), .dbg_regs(dbg[1]));
   regfile_sb #(.BYPASS(1'b1), .ZERO_R0(1'b1)) u2 (
      .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy[2]),
      .ra_addr(ra_addr), .ra_data(rad[2]), .ra_pend(rap[2]),
      .rb_addr(rb_addr), .rb_data(rbd[2]), .rb_pend(rbp[2]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(err[2]), .dbg_regs(dbg[2]));
   typedef struct {
      logic        wen;
      logic [2:0]  waddr;
      logic [15:0] wdata;
      logic [1:0]  wbe;
      logic        ren;
      logic [2:0]  raddr;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [15:0] e_ra0;
      logic [15:0] e_ra1;
      logic [15:0] e_ra2;
      logic [15:0] e_rb;
      logic        e_rap;
      logic        e_rbp;
      logic        e_rap2;
      logic        e_err;
      logic        e_err2;
   } vec_t;
   vec_t v [18];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic idle();
      clear_req = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
      wr_addr = '0; wr_data = '0; wr_be = '0; rsv_addr = '0;
   endtask
   task automatic count_clear(input string nm);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("%s busy c%0d", nm, c), 32'(rdy[0]), 32'd0);
         chk($sformatf("%s ra0 c%0d", nm, c), 32'(rad[0]), 32'd0);
         chk($sformatf("%s pend c%0d", nm, c), 32'(rbp[0]), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      chk($sformatf("%s ready", nm), 32'(rdy[0]), 32'd1);
      chk($sformatf("%s ready u2", nm), 32'(rdy[2]), 32'd1);
   endtask
   initial begin
      v[0]  = '{1'b1, 3'd3, 16'hABCD, 2'b11, 1'b0, 3'd0, 3'd3, 3'd3, 16'hABCD, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[1]  = '{1'b1, 3'd3, 16'h1200, 2'b10, 1'b0, 3'd0, 3'd3, 3'd3, 16'h12CD, 16'hABCD, 16'h12CD, 16'h12CD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[2]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd3, 3'd0, 16'h12CD, 16'h12CD, 16'h12CD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[3]  = '{1'b1, 3'd5, 16'h5A5A, 2'b11, 1'b0, 3'd0, 3'd5, 3'd3, 16'h5A5A, 16'h0000, 16'h5A5A, 16'h12CD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[4]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2, 3'd5, 3'd2, 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[5]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2, 3'd2, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      v[6]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd2, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      v[7]  = '{1'b1, 3'd2, 16'h00FF, 2'b01, 1'b0, 3'd0, 3'd2, 3'd2, 16'h00FF, 16'h0000, 16'h00FF, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      v[8]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd2, 3'd2, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[9]  = '{1'b1, 3'd2, 16'h1100, 2'b10, 1'b1, 3'd2, 3'd2, 3'd2, 16'h11FF, 16'h00FF, 16'h11FF, 16'h11FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[10] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd2, 3'd2, 16'h11FF, 16'h11FF, 16'h11FF, 16'h11FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      v[11] = '{1'b1, 3'd2, 16'hFFFF, 2'b00, 1'b0, 3'd0, 3'd2, 3'd2, 16'h11FF, 16'h11FF, 16'h11FF, 16'h11FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      v[12] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd2, 3'd2, 16'h11FF, 16'h11FF, 16'h11FF, 16'h11FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[13] = '{1'b1, 3'd0, 16'hFFFF, 2'b11, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[14] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      v[15] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      v[16] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      v[17] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd7, 3'd5, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      idle();
      ra_addr = '0; rb_addr = '0;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("reset ready", 32'(rdy[0]), 32'd0);
      chk("reset rsv_err", 32'(err[0]), 32'd0);
      rst = 1'b0;
      count_clear("init");
      for (int n = 0; n < 3; n++)
         for (int k = 0; k < 8; k++)
            chk($sformatf("init dbg u%0d r%0d", n, k), 32'(dbg[n][k*16 +: 16]), 32'd0);
      for (int i = 0; i < 18; i++) begin
         wr_en = v[i].wen; wr_addr = v[i].waddr; wr_data = v[i].wdata; wr_be = v[i].wbe;
         rsv_en = v[i].ren; rsv_addr = v[i].raddr; ra_addr = v[i].ra; rb_addr = v[i].rb;
         #2;
         chk($sformatf("v%0d ra u0", i), 32'(rad[0]), 32'(v[i].e_ra0));
         chk($sformatf("v%0d ra u1", i), 32'(rad[1]), 32'(v[i].e_ra1));
         chk($sformatf("v%0d ra u2", i), 32'(rad[2]), 32'(v[i].e_ra2));
         chk($sformatf("v%0d rb u0", i), 32'(rbd[0]), 32'(v[i].e_rb));
         chk($sformatf("v%0d ra_pend u0", i), 32'(rap[0]), 32'(v[i].e_rap));
         chk($sformatf("v%0d rb_pend u0", i), 32'(rbp[0]), 32'(v[i].e_rbp));
         chk($sformatf("v%0d ra_pend u2", i), 32'(rap[2]), 32'(v[i].e_rap2));
         chk($sformatf("v%0d rsv_err u0", i), 32'(err[0]), 32'(v[i].e_err));
         chk($sformatf("v%0d rsv_err u2", i), 32'(err[2]), 32'(v[i].e_err2));
         @(posedge clk); @(negedge clk);
      end
      idle();
      #1;
      chk("dbg u0 r0", 32'(dbg[0][0 +: 16]), 32'h0000FFFF);
      chk("dbg u2 r0", 32'(dbg[2][0 +: 16]), 32'h00000000);
      chk("dbg u0 r3", 32'(dbg[0][48 +: 16]), 32'h000012CD);
      chk("dbg u0 r5", 32'(dbg[0][80 +: 16]), 32'h00005A5A);
      chk("dbg u1 r2", 32'(dbg[1][32 +: 16]), 32'h000011FF);
      @(negedge clk);
      clear_req = 1'b1;
      chk("pre-clear ready", 32'(rdy[0]), 32'd1);
      @(posedge clk); @(negedge clk);
      clear_req = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h7777; wr_be = 2'b11;
      rsv_en = 1'b1; rsv_addr = 3'd6; ra_addr = 3'd3; rb_addr = 3'd0;
      count_clear("clr");
      idle();
      #1;
      chk("clr rsv_err", 32'(err[0]), 32'd0);
      for (int n = 0; n < 3; n++)
         for (int k = 0; k < 8; k++)
            chk($sformatf("clr dbg u%0d r%0d", n, k), 32'(dbg[n][k*16 +: 16]), 32'd0);
      for (int a = 0; a < 8; a++) begin
         ra_addr = 3'(a);
         #1;
         chk($sformatf("clr pend r%0d", a), 32'(rap[0]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("mid busy c%0d", c), 32'(rdy[2]), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      count_clear("restart");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
